z80_read_mux: RTL and testbench

Parametrised, wait-state-aware successor to the Z80 data-input multiplexer. It selects one of NCH device read buses onto the Z80 DATA IN bus by fixed priority. It inserts a per-channel programmable number of wait cycles and asserts a ready flag when data is valid. It also forces 8'h00 (NOP) during reset fetches and records select collisions and aborted reads.

---
 rtl/z80_read_mux.sv | 172 +++++++++++++++++
 tb/tb_z80_read_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/z80_read_mux.sv
// z80_read_mux
//   Selects one of NCH device read buses onto the Z80 DATA IN bus.
//   Channel 0 has the highest priority. When no channel select is set,
//   the bus falls back to s100DataIn.
//   Each channel has its own programmable wait-state count. rdReady rises
//   once the captured data is valid on outData.
//   reset_cs forces DEFAULT_DATA (a NOP) for reset-vector fetches.
//   Sticky flags record select collisions and aborted reads.
//
// Ports
//   pll0_250MHz : system clock, rising edge
//   reset       : synchronous active-high reset
//   chData      : NCH*DW read data, channel i at [i*DW +: DW]
//   chCs        : NCH per-channel selects
//   wsCfg       : NCH*WSW wait counts, channel i at [i*WSW +: WSW]
//   s100DataIn  : fallback data when no select is set
//   reset_cs    : reset-vector fetch, forces DEFAULT_DATA and rdReady
//   z80Read     : read request (level)
//   errClr      : clears collision / abortErr (a same-cycle set wins)
//   outData     : Z80 DATA IN
//   rdReady     : data valid, releases the CPU wait
//   selIdx      : locked source, NCH = fallback
//   collision   : sticky, more than one select was set at lock
//   abortErr    : sticky, the locked channel dropped its select before capture
//   dbgState    : current FSM state (IDLE=0, WAIT=1, CAPT=2, DONE=3)
//
// Handshake: z80Read is a level request. rdReady stays high while
// z80Read is held. Dropping z80Read in any state returns the FSM to IDLE,
// with rdReady low one edge later.
module z80_read_mux #(
    parameter int              NCH          = 8,
    parameter int              DW           = 8,
    parameter int              WSW          = 4,
    parameter logic [DW-1:0]   DEFAULT_DATA = '0
) (
    input  logic                      pll0_250MHz,
    input  logic                      reset,
    input  logic [NCH*DW-1:0]         chData,
    input  logic [NCH-1:0]            chCs,
    input  logic [NCH*WSW-1:0]        wsCfg,
    input  logic [DW-1:0]             s100DataIn,
    input  logic                      reset_cs,
    input  logic                      z80Read,
    input  logic                      errClr,
    output logic [DW-1:0]             outData,
    output logic                      rdReady,
    output logic [$clog2(NCH):0]      selIdx,
    output logic                      collision,
    output logic                      abortErr,
    output logic [1:0]                dbgState
);

    localparam int SW = $clog2(NCH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [WSW-1:0] counter;

    // Lock-cycle decode: lowest set select, its wait count, multiple hits
    logic [SW-1:0]  firstIdx;
    logic [WSW-1:0] firstWs;
    logic           multiHit;
    logic           anySeen;

    // Data path of the channel already locked in selIdx
    logic [DW-1:0]  lockedData;
    logic           lockedCs;

    logic           lockNow;
    logic           collSet;
    logic           abortSet;

    always_comb begin
        firstIdx = SW'(NCH);
        firstWs  = '0;
        multiHit = 1'b0;
        anySeen  = 1'b0;
        // Scan from the top down so the lowest index is the last writer
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chCs[i]) begin
                firstIdx = SW'(i);
                firstWs  = wsCfg[i*WSW +: WSW];
                if (anySeen) multiHit = 1'b1;
                anySeen = 1'b1;
            end
        end
    end

    always_comb begin
        // Fallback source: always "selected", so it can never abort
        lockedData = s100DataIn;
        lockedCs   = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (selIdx == SW'(i)) begin
                lockedData = chData[i*DW +: DW];
                lockedCs   = chCs[i];
            end
        end
    end

    assign lockNow  = !reset_cs && (state == IDLE) && z80Read;
    assign collSet  = lockNow && multiHit;
    assign abortSet = !reset_cs && (state == CAPT) && z80Read && !lockedCs;
    assign dbgState = state;

    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            outData   <= DEFAULT_DATA;
            rdReady   <= 1'b0;
            selIdx    <= '0;
            collision <= 1'b0;
            abortErr  <= 1'b0;
        end else begin
            // Sticky flags: set has priority over clear
            collision <= collSet  | (collision & ~errClr);
            abortErr  <= abortSet | (abortErr  & ~errClr);

            if (reset_cs) begin
                outData <= DEFAULT_DATA;
                rdReady <= 1'b1;
                state   <= IDLE;
                counter <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Also drops the rdReady left high by reset_cs
                        rdReady <= 1'b0;
                        if (z80Read) begin
                            selIdx  <= firstIdx;
                            counter <= firstWs;
                            state   <= (firstWs != '0) ? WAIT : CAPT;
                        end
                    end
                    WAIT: begin
                        if (!z80Read) begin
                            state   <= IDLE;
                            counter <= '0;
                        end else begin
                            counter <= counter - 1'b1;
                            if (counter == WSW'(1)) state <= CAPT;
                        end
                    end
                    CAPT: begin
                        if (!z80Read) begin
                            state <= IDLE;
                        end else begin
                            outData <= lockedCs ? lockedData : DEFAULT_DATA;
                            rdReady <= 1'b1;
                            state   <= DONE;
                        end
                    end
                    DONE: begin
                        if (!z80Read) begin
                            rdReady <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z80_read_mux.sv
// Directed bench for z80_read_mux. Inputs change 1 ns after a rising edge;
// outputs are checked at that same point, well away from the next edge.
module tb_z80_read_mux;

    localparam int NCH = 8;
    localparam int DW  = 8;
    localparam int WSW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic                 clk;
    logic                 reset;
    logic [NCH*DW-1:0]    chData;
    logic [NCH-1:0]       chCs;
    logic [NCH*WSW-1:0]   wsCfg;
    logic [DW-1:0]        s100DataIn;
    logic                 reset_cs;
    logic                 z80Read;
    logic                 errClr;
    logic [DW-1:0]        outData;
    logic                 rdReady;
    logic [3:0]           selIdx;
    logic                 collision;
    logic                 abortErr;
    logic [1:0]           dbgState;

    int tests_run = 0;
    int tests_failed = 0;

    z80_read_mux #(
        .NCH(NCH), .DW(DW), .WSW(WSW), .DEFAULT_DATA(8'h00)
    ) dut (
        .pll0_250MHz (clk),
        .reset       (reset),
        .chData      (chData),
        .chCs        (chCs),
        .wsCfg       (wsCfg),
        .s100DataIn  (s100DataIn),
        .reset_cs    (reset_cs),
        .z80Read     (z80Read),
        .errClr      (errClr),
        .outData     (outData),
        .rdReady     (rdReady),
        .selIdx      (selIdx),
        .collision   (collision),
        .abortErr    (abortErr),
        .dbgState    (dbgState)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; chData = '0; chCs = '0; wsCfg = '0; s100DataIn = '0;
        reset_cs = 1'b0; z80Read = 1'b0; errClr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_outData",   32'(outData),   32'h00);
        chk("rst_rdReady",   32'(rdReady),   32'h0);
        chk("rst_selIdx",    32'(selIdx),    32'h0);
        chk("rst_collision", 32'(collision), 32'h0);
        chk("rst_abortErr",  32'(abortErr),  32'h0);
        chk("rst_state",     32'(dbgState),  32'(S_IDLE));
        tick();

        // Channel 3, two wait states, data A5: rdReady after 4 edges
        chCs = 8'b0000_1000; wsCfg = 32'h0000_2000; chData = 64'h0000_0000_A500_0000;
        z80Read = 1'b1;
        tick(); chk("ch3_e1_state", 32'(dbgState), 32'(S_WAIT));
        tick(); chk("ch3_e2_rdy",   32'(rdReady),  32'h0);
        tick(); chk("ch3_e3_rdy",   32'(rdReady),  32'h0);
                chk("ch3_e3_state", 32'(dbgState), 32'(S_CAPT));
        tick(); chk("ch3_e4_rdy",   32'(rdReady),  32'h1);
                chk("ch3_data",     32'(outData),  32'hA5);
                chk("ch3_sel",      32'(selIdx),   32'h3);
        z80Read = 1'b0;
        tick(); chk("ch3_rdy_drop", 32'(rdReady),  32'h0);
                chk("ch3_idle",     32'(dbgState), 32'(S_IDLE));

        // Collision: channels 1 and 2, no wait states
        chCs = 8'b0000_0110; wsCfg = '0; chData = 64'h0000_0000_0077_5A00;
        z80Read = 1'b1;
        tick(); chk("col_state", 32'(dbgState),  32'(S_CAPT));
                chk("col_sel",   32'(selIdx),    32'h1);
                chk("col_flag",  32'(collision), 32'h1);
        tick(); chk("col_rdy",   32'(rdReady),   32'h1);
                chk("col_data",  32'(outData),   32'h5A);
        z80Read = 1'b0; errClr = 1'b1;
        tick(); chk("col_clr",   32'(collision), 32'h0);
                chk("col_rdy0",  32'(rdReady),   32'h0);
        errClr = 1'b0;

        // Fallback source
        chCs = '0; s100DataIn = 8'h3C; z80Read = 1'b1;
        tick(); chk("fb_sel",  32'(selIdx),  32'h8);
                chk("fb_rdy1", 32'(rdReady), 32'h0);
        tick(); chk("fb_rdy2", 32'(rdReady), 32'h1);
                chk("fb_data", 32'(outData), 32'h3C);
        z80Read = 1'b0;
        tick();

        // z80Read drops during WAIT: outData holds 3C
        chCs = 8'b0000_1000; wsCfg = 32'h0000_2000; chData = 64'h0000_0000_A500_0000;
        z80Read = 1'b1;
        tick(); chk("drop_wait", 32'(dbgState), 32'(S_WAIT));
        z80Read = 1'b0;
        tick(); chk("drop_state", 32'(dbgState), 32'(S_IDLE));
                chk("drop_rdy",   32'(rdReady),  32'h0);
                chk("drop_data",  32'(outData),  32'h3C);

        // reset_cs mid-WAIT on channel 7 (15 wait states)
        chCs = 8'b1000_0000; wsCfg = 32'hF000_0000; chData = 64'hC300_0000_0000_0000;
        z80Read = 1'b1;
        tick(); tick(); chk("rcs_wait", 32'(dbgState), 32'(S_WAIT));
        reset_cs = 1'b1;
        tick(); chk("rcs_data",  32'(outData),  32'h00);
                chk("rcs_rdy",   32'(rdReady),  32'h1);
                chk("rcs_state", 32'(dbgState), 32'(S_IDLE));
        reset_cs = 1'b0; z80Read = 1'b0;
        tick(); chk("rcs_fall_rdy", 32'(rdReady), 32'h0);

        // Abort: channel 5, three wait states, select drops during WAIT
        chCs = 8'b0010_0000; wsCfg = 32'h0030_0000; chData = 64'h0000_9900_0000_0000;
        z80Read = 1'b1;
        tick(); chCs = '0;
        tick(); tick();
        tick(); chk("ab_e4_rdy",  32'(rdReady),  32'h0);
                chk("ab_e4_state", 32'(dbgState), 32'(S_CAPT));
        tick(); chk("ab_rdy",     32'(rdReady),  32'h1);
                chk("ab_data",    32'(outData),  32'h00);
                chk("ab_flag",    32'(abortErr), 32'h1);
                chk("ab_sel",     32'(selIdx),   32'h5);
                chk("ab_nocol",   32'(collision), 32'h0);
        z80Read = 1'b0; errClr = 1'b1;
        tick(); chk("ab_clr", 32'(abortErr), 32'h0);

        // Collision set in the same cycle as errClr: set wins
        chCs = 8'b0000_0011; wsCfg = '0; chData = 64'h0000_0000_0000_2211;
        z80Read = 1'b1;
        tick(); chk("setwin_flag", 32'(collision), 32'h1);
                chk("setwin_sel",  32'(selIdx),    32'h0);
        errClr = 1'b0; z80Read = 1'b0;
        tick(); chk("capt_drop_state", 32'(dbgState), 32'(S_IDLE));
                chk("capt_drop_rdy",   32'(rdReady),  32'h0);
                chk("capt_drop_data",  32'(outData),  32'h00);

        // Reach DONE on channel 0, then reset
        chCs = 8'b0000_0001; z80Read = 1'b1;
        tick(); tick();
        chk("done_state", 32'(dbgState), 32'(S_DONE));
        chk("done_data",  32'(outData),  32'h11);
        tick(); chk("done_hold", 32'(rdReady), 32'h1);
        reset = 1'b1;
        tick();
        chk("rst2_outData",   32'(outData),   32'h00);
        chk("rst2_rdReady",   32'(rdReady),   32'h0);
        chk("rst2_selIdx",    32'(selIdx),    32'h0);
        chk("rst2_collision", 32'(collision), 32'h0);
        chk("rst2_abortErr",  32'(abortErr),  32'h0);
        chk("rst2_state",     32'(dbgState),  32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
